// File: rtl/key_led_pkg.sv
// Shared mode codes, LED patterns and default timing for the key/LED scheduler.
package key_led_pkg;

  localparam int MODE_W   = 3;
  localparam int NUM_KEYS = 4;

  // Defaults assume a 50 MHz sys_clk: 20 ms debounce, 0.2 s pattern step.
  localparam int DEF_DEBOUNCE_CYC = 1_000_000;
  localparam int DEF_STEP_CYC     = 10_000_000;
  localparam int DEF_CNT_W        = 24;

  typedef enum logic [MODE_W-1:0] {
    IDLE  = 3'd0,
    M_R   = 3'd1,
    M_L   = 3'd2,
    M_ALT = 3'd3,
    M_ON  = 3'd4
  } mode_e;

  // Running-right sequence; the left runner plays it backwards.
  localparam logic [3:0] PAT_R0    = 4'b1000;
  localparam logic [3:0] PAT_R1    = 4'b0100;
  localparam logic [3:0] PAT_R2    = 4'b0010;
  localparam logic [3:0] PAT_R3    = 4'b0001;
  localparam logic [3:0] PAT_ALT_E = 4'b1010;
  localparam logic [3:0] PAT_ALT_O = 4'b0101;
  localparam logic [3:0] PAT_ON    = 4'b1111;
  localparam logic [3:0] PAT_OFF   = 4'b0000;

endpackage

// File: rtl/key_debounce.sv
// One key: 2-flop synchroniser, debounce counter, stable level and a
// registered one-cycle press pulse on an accepted 1->0 change.
module key_debounce
  import key_led_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic press
);

  localparam logic [CNT_W-1:0] DEB_TC = CNT_W'(DEBOUNCE_CYC - 1);

  logic [1:0]       sync_q, sync_d;
  logic [1:0]       vld_q, vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             armed_q, armed_d;
  logic             press_q, press_d;

  // Next-state: sync shift, debounce counting and press generation.
  // armed only sets once a released level has been seen through the
  // synchroniser, so a key held across reset cannot fire on its first
  // acceptance.
  always_comb begin
    sync_d   = {sync_q[0], key_in};
    vld_d    = {vld_q[0], 1'b1};
    cnt_d    = cnt_q;
    stable_d = stable_q;
    press_d  = 1'b0;
    armed_d  = armed_q | (vld_q[1] & sync_q[1]);
    if (sync_q[1] == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == DEB_TC) begin
      cnt_d    = '0;
      stable_d = sync_q[1];
      press_d  = ~sync_q[1] & armed_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers; keys reset to the released level.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q   <= 2'b11;
      vld_q    <= 2'b00;
      cnt_q    <= '0;
      stable_q <= 1'b1;
      armed_q  <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      vld_q    <= vld_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      armed_q  <= armed_d;
      press_q  <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/key_led_sched.sv
// Key-driven LED pattern controller: debounced presses pick a mode, a
// prescaler steps the pattern, and the (mode, step) pair is decoded to led.
//
// state | meaning
// IDLE  | all LEDs off, no stepping
// M_R   | single LED running right (key0)
// M_L   | single LED running left  (key1)
// M_ALT | alternating 1010/0101    (key2)
// M_ON  | all LEDs on, no stepping (key3)
module key_led_sched
  import key_led_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int STEP_CYC     = DEF_STEP_CYC,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [NUM_KEYS-1:0] key,
  output logic [3:0]          led,
  output logic [MODE_W-1:0]   mode,
  output logic [1:0]          step
);

  localparam logic [CNT_W-1:0] STEP_TC = CNT_W'(STEP_CYC - 1);

  logic [NUM_KEYS-1:0] press;
  logic                win_vld;
  mode_e               win_mode;
  mode_e               mode_q, mode_d;
  logic [1:0]          step_q, step_d;
  logic [CNT_W-1:0]    pre_q, pre_d;
  logic [3:0]          led_q, led_d;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .CNT_W       (CNT_W)
    ) u_deb (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .key_in   (key[k]),
      .press    (press[k])
    );
  end

  // Lowest-index press wins; simultaneous losers are dropped.
  always_comb begin
    win_vld  = 1'b1;
    win_mode = IDLE;
    if (press[0])      win_mode = M_R;
    else if (press[1]) win_mode = M_L;
    else if (press[2]) win_mode = M_ALT;
    else if (press[3]) win_mode = M_ON;
    else               win_vld  = 1'b0;
  end

  // Mode transitions and step prescaler; a press overrides a same-cycle
  // terminal count.
  always_comb begin
    mode_d = mode_q;
    step_d = step_q;
    pre_d  = pre_q;
    case (mode_q)
      IDLE, M_R, M_L, M_ALT, M_ON: begin
        if (win_vld) begin
          mode_d = (mode_q == win_mode) ? IDLE : win_mode;
          step_d = 2'd0;
          pre_d  = '0;
        end else if (mode_q == M_R || mode_q == M_L || mode_q == M_ALT) begin
          if (pre_q == STEP_TC) begin
            pre_d  = '0;
            step_d = step_q + 2'd1;
          end else begin
            pre_d = pre_q + CNT_W'(1);
          end
        end else begin
          pre_d  = '0;
          step_d = 2'd0;
        end
      end
      default: begin
        mode_d = IDLE;
        step_d = 2'd0;
        pre_d  = '0;
      end
    endcase
  end

  // Pattern decode of the current (mode, step); registered into led_q.
  always_comb begin
    led_d = PAT_OFF;
    case (mode_q)
      IDLE: led_d = PAT_OFF;
      M_R: begin
        case (step_q)
          2'd0:    led_d = PAT_R0;
          2'd1:    led_d = PAT_R1;
          2'd2:    led_d = PAT_R2;
          default: led_d = PAT_R3;
        endcase
      end
      M_L: begin
        case (step_q)
          2'd0:    led_d = PAT_R3;
          2'd1:    led_d = PAT_R2;
          2'd2:    led_d = PAT_R1;
          default: led_d = PAT_R0;
        endcase
      end
      M_ALT:   led_d = step_q[0] ? PAT_ALT_O : PAT_ALT_E;
      M_ON:    led_d = PAT_ON;
      default: led_d = PAT_OFF;
    endcase
  end

  // Mode, step, prescaler and LED registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mode_q <= IDLE;
      step_q <= 2'd0;
      pre_q  <= '0;
      led_q  <= PAT_OFF;
    end else begin
      mode_q <= mode_d;
      step_q <= step_d;
      pre_q  <= pre_d;
      led_q  <= led_d;
    end
  end

  assign led  = led_q;
  assign mode = mode_q;
  assign step = step_q;

endmodule

// File: tb/tb_key_led_sched.sv
// Bench for key_led_sched: directed scenarios plus random key activity,
// compared every cycle against a timing-level reference model.
module tb_key_led_sched;

  localparam int DEB  = 4;
  localparam int STEP = 8;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [3:0] key = 4'hF;
  logic [3:0] led;
  logic [2:0] mode;
  logic [1:0] step;

  int n_chk = 0;
  int n_err = 0;

  key_led_sched #(.DEBOUNCE_CYC(DEB), .STEP_CYC(STEP), .CNT_W(24)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .key      (key),
    .led      (led),
    .mode     (mode),
    .step     (step)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model state
  logic [3:0] m_h1, m_h2;
  logic [3:0] m_stable, m_armed, m_press, m_led;
  int         m_run [4];
  int         m_edges, m_mode, m_t, m_step;

  function automatic logic [3:0] pat(input int md, input int st);
    logic [3:0] r1 = 4'b1000;
    logic [3:0] l1 = 4'b0001;
    case (md)
      1:       return r1 >> st;
      2:       return l1 << st;
      3:       return (st % 2 == 1) ? 4'b0101 : 4'b1010;
      4:       return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic model_reset();
    m_h1 = 4'hF; m_h2 = 4'hF;
    m_stable = 4'hF; m_armed = 4'h0; m_press = 4'h0; m_led = 4'h0;
    for (int k = 0; k < 4; k++) m_run[k] = 0;
    m_edges = 0; m_mode = 0; m_t = 0; m_step = 0;
  endtask

  // Advance the model by one clock edge; all reads use pre-edge values.
  task automatic model_clk(input logic [3:0] pin);
    logic [3:0] synced;
    logic [3:0] new_press;
    bit         valid;
    int         win;
    valid     = (m_edges >= 2);
    synced    = valid ? m_h2 : 4'hF;
    new_press = 4'h0;
    m_led     = pat(m_mode, m_step);
    for (int k = 0; k < 4; k++) begin
      if (synced[k] != m_stable[k]) begin
        m_run[k]++;
        if (m_run[k] == DEB) begin
          m_stable[k] = synced[k];
          m_run[k] = 0;
          if (!synced[k] && m_armed[k]) new_press[k] = 1'b1;
        end
      end else begin
        m_run[k] = 0;
      end
      if (valid && synced[k]) m_armed[k] = 1'b1;
    end
    win = -1;
    for (int k = 3; k >= 0; k--) if (m_press[k]) win = k;
    if (win >= 0) begin
      m_mode = (m_mode == win + 1) ? 0 : win + 1;
      m_t = 0;
    end else if (m_mode >= 1 && m_mode <= 3) begin
      m_t++;
    end else begin
      m_t = 0;
    end
    m_step  = (m_t / STEP) % 4;
    m_press = new_press;
    m_h2    = m_h1;
    m_h1    = pin;
    m_edges++;
  endtask

  initial model_reset();

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) model_reset();
    else            model_clk(key);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      chk("model_led",  32'(led),  32'(m_led));
      chk("model_mode", 32'(mode), 32'(m_mode));
      chk("model_step", 32'(step), 32'(m_step));
    end
  endtask

  initial begin
    int p;
    // 1: reset and idle hold
    cyc(3);
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_mode", 32'(mode), 32'h0);
    chk("rst_step", 32'(step), 32'h0);
    sys_rst_n = 1'b1;
    cyc(50);
    chk("idle_led", 32'(led), 32'h0);
    chk("idle_mode", 32'(mode), 32'h0);

    // 2: 3-cycle glitch on key0 is rejected
    key[0] = 1'b0;
    cyc(3);
    key[0] = 1'b1;
    cyc(20);
    chk("glitch_mode", 32'(mode), 32'h0);
    chk("glitch_led", 32'(led), 32'h0);

    // 3: key0 held, exact latency then running-right with wrap
    key[0] = 1'b0;
    cyc(7);
    chk("lat_before", 32'(led), 32'h0);
    cyc(1);
    chk("lat_r0", 32'(led), 32'b1000);
    cyc(8);  chk("r_step1", 32'(led), 32'b0100);
    cyc(8);  chk("r_step2", 32'(led), 32'b0010);
    cyc(8);  chk("r_step3", 32'(led), 32'b0001);
    cyc(8);  chk("r_wrap",  32'(led), 32'b1000);
    key[0] = 1'b1;
    cyc(12);

    // 4: key2 switches to ALT, key2 again returns to IDLE
    key[2] = 1'b0;
    cyc(7);
    chk("alt_mode", 32'(mode), 32'd3);
    chk("alt_step", 32'(step), 32'd0);
    cyc(1);  chk("alt_even", 32'(led), 32'b1010);
    cyc(8);  chk("alt_odd",  32'(led), 32'b0101);
    key[2] = 1'b1;
    cyc(12);
    key[2] = 1'b0;
    cyc(7);
    chk("alt_off_mode", 32'(mode), 32'd0);
    cyc(1);
    chk("alt_off_led", 32'(led), 32'h0);
    key[2] = 1'b1;
    cyc(12);

    // 5: key1 and key3 together, key1 wins
    key[1] = 1'b0;
    key[3] = 1'b0;
    cyc(7);
    chk("arb_mode", 32'(mode), 32'd2);
    cyc(1);
    chk("arb_led", 32'(led), 32'b0001);
    cyc(15);
    chk("arb_step2", 32'(step), 32'd2);
    chk("arb_not_on", 32'(mode), 32'd2);

    // 6: reset with key1 held; needs release and re-press
    key[3] = 1'b1;
    sys_rst_n = 1'b0;
    #1;
    chk("rst_mid_led", 32'(led), 32'h0);
    chk("rst_mid_mode", 32'(mode), 32'h0);
    cyc(1);
    sys_rst_n = 1'b1;
    cyc(30);
    chk("held_mode", 32'(mode), 32'h0);
    chk("held_led", 32'(led), 32'h0);
    key[1] = 1'b1;
    cyc(12);
    key[1] = 1'b0;
    cyc(7);
    chk("repress_mode", 32'(mode), 32'd2);
    cyc(1);
    chk("repress_led", 32'(led), 32'b0001);
    key[1] = 1'b1;
    cyc(12);

    // Random key activity with occasional resets
    for (int blk = 0; blk < 8; blk++) begin
      p = (blk % 2 == 0) ? 5 : 24;
      for (int c = 0; c < 400; c++) begin
        for (int k = 0; k < 4; k++)
          if ($urandom_range(0, p) == 0) key[k] = ~key[k];
        sys_rst_n = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
        cyc(1);
      end
    end
    sys_rst_n = 1'b1;
    key = 4'hF;
    cyc(20);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
